// File: rtl/tape_ear_decoder_pkg.sv
// Shared tape-link definitions: tone defaults, half-wave classes, error codes, decoder states.
// Also used by the playback generator side of the link.
package tape_ear_decoder_pkg;

  localparam int unsigned DEF_CLK_FREQ   = 27000000;
  localparam int unsigned DEF_BIT0_FREQ  = 2400;
  localparam int unsigned DEF_BIT1_FREQ  = 1200;
  localparam int unsigned DEF_PILOT_LOCK = 4;

  // Half-wave length in clocks of a square tone at freq.
  function automatic int unsigned half_wave(input int unsigned clk_freq, input int unsigned freq);
    return clk_freq / (2 * freq);
  endfunction

  typedef enum logic [1:0] {
    HW_GLITCH  = 2'd0,
    HW_SHORT   = 2'd1,
    HW_LONG    = 2'd2,
    HW_TIMEOUT = 2'd3
  } hw_class_e;

  localparam logic [1:0] ERR_GLITCH  = 2'd1;
  localparam logic [1:0] ERR_PAIR    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_SEEK  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

endpackage

// File: rtl/tape_ear_decoder_pulse_meter.sv
// EAR front end: synchronises ear_in, detects either edge, measures half-wave width
// and emits one classified strobe per half-wave (or one when the width saturates).
module tape_ear_decoder_pulse_meter
  import tape_ear_decoder_pkg::*;
#(
  parameter int unsigned MIN_W   = 2812,
  parameter int unsigned SPLIT_W = 8437,
  parameter int unsigned MAX_W   = 16875
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ear_in,
  output logic       hw_valid,
  output logic [1:0] hw_class
);

  localparam logic [15:0] MIN16   = 16'(MIN_W);
  localparam logic [15:0] SPLIT16 = 16'(SPLIT_W);
  localparam logic [15:0] MAX16   = 16'(MAX_W);

  logic        sync1, sync2, sync3;
  logic        edge_det;
  logic [15:0] width;
  hw_class_e   cls_now;
  hw_class_e   class_q;
  logic        valid_q;

  // Two-flop synchroniser followed by the edge reference register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ear_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_det = sync2 ^ sync3;

  // Classify the width accumulated so far; anything past MAX is a timeout.
  always_comb begin
    cls_now = HW_TIMEOUT;
    if (width < MIN16)
      cls_now = HW_GLITCH;
    else if (width < SPLIT16)
      cls_now = HW_SHORT;
    else if (width <= MAX16)
      cls_now = HW_LONG;
  end

  // Width counter restarting at 1 on each edge, saturating at MAX+1; the
  // saturation step (pre-increment value == MAX) raises the single timeout strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      width   <= '0;
      valid_q <= 1'b0;
      class_q <= HW_GLITCH;
    end else begin
      valid_q <= 1'b0;
      if (edge_det) begin
        width   <= 16'd1;
        valid_q <= 1'b1;
        class_q <= cls_now;
      end else if (width <= MAX16) begin
        width <= width + 16'd1;
        if (width == MAX16) begin
          valid_q <= 1'b1;
          class_q <= HW_TIMEOUT;
        end
      end
    end
  end

  assign hw_valid = valid_q;
  assign hw_class = class_q;

endmodule

// File: rtl/tape_ear_decoder.sv
// Tape EAR receiver: pilot lock, bit-pair decoding into MSB-first bytes,
// per-block byte count and XOR checksum, error reporting.
module tape_ear_decoder
  import tape_ear_decoder_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BIT0_FREQ  = DEF_BIT0_FREQ,
  parameter int unsigned BIT1_FREQ  = DEF_BIT1_FREQ,
  parameter int unsigned PILOT_LOCK = DEF_PILOT_LOCK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        ear_in,
  input  logic [15:0] blk_len,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        block_done,
  output logic        chk_ok,
  output logic        locked,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int unsigned BIT0_HALF = half_wave(CLK_FREQ, BIT0_FREQ);
  localparam int unsigned BIT1_HALF = half_wave(CLK_FREQ, BIT1_FREQ);
  localparam int unsigned MIN_W     = BIT0_HALF / 2;
  localparam int unsigned SPLIT_W   = (BIT0_HALF + BIT1_HALF) / 2;
  localparam int unsigned MAX_W     = BIT1_HALF * 3 / 2;
  localparam logic [7:0]  LOCK_LAST = 8'(PILOT_LOCK - 1);

  logic       hw_valid;
  logic [1:0] hw_class_raw;
  hw_class_e  hw_cls;

  tape_ear_decoder_pulse_meter #(
    .MIN_W   (MIN_W),
    .SPLIT_W (SPLIT_W),
    .MAX_W   (MAX_W)
  ) u_meter (
    .clk      (clk),
    .reset    (reset),
    .ear_in   (ear_in),
    .hw_valid (hw_valid),
    .hw_class (hw_class_raw)
  );

  assign hw_cls = hw_class_e'(hw_class_raw);

  state_e      state_q, state_n;
  logic [7:0]  pilot_q, pilot_n;
  logic [15:0] len_q, len_n;
  logic [15:0] bytes_q, bytes_n;
  logic [7:0]  xor_q, xor_n;
  logic [7:0]  shift_q, shift_n;
  logic [2:0]  bits_q, bits_n;
  logic        half_q, half_n;
  logic        first_long_q, first_long_n;
  logic [7:0]  byte_data_q, byte_data_n;
  logic        byte_valid_q, byte_valid_n;
  logic        block_done_q, block_done_n;
  logic        chk_ok_q, chk_ok_n;
  logic        err_q, err_n;
  logic [1:0]  err_code_q, err_code_n;

  logic        new_bit;
  logic [7:0]  shifted;
  logic [7:0]  xor_next;
  logic [15:0] bytes_inc;

  assign new_bit   = (hw_cls == HW_LONG);
  assign shifted   = {shift_q[6:0], new_bit};
  assign xor_next  = xor_q ^ shifted;
  assign bytes_inc = bytes_q + 16'd1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SEEK;
      pilot_q      <= '0;
      len_q        <= '0;
      bytes_q      <= '0;
      xor_q        <= '0;
      shift_q      <= '0;
      bits_q       <= '0;
      half_q       <= 1'b0;
      first_long_q <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      block_done_q <= 1'b0;
      chk_ok_q     <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_n;
      pilot_q      <= pilot_n;
      len_q        <= len_n;
      bytes_q      <= bytes_n;
      xor_q        <= xor_n;
      shift_q      <= shift_n;
      bits_q       <= bits_n;
      half_q       <= half_n;
      first_long_q <= first_long_n;
      byte_data_q  <= byte_data_n;
      byte_valid_q <= byte_valid_n;
      block_done_q <= block_done_n;
      chk_ok_q     <= chk_ok_n;
      err_q        <= err_n;
      err_code_q   <= err_code_n;
    end
  end

  // Next-state logic: pilot counting, arming, pair decoding, byte/block completion, errors.
  always_comb begin
    state_n      = state_q;
    pilot_n      = pilot_q;
    len_n        = len_q;
    bytes_n      = bytes_q;
    xor_n        = xor_q;
    shift_n      = shift_q;
    bits_n       = bits_q;
    half_n       = half_q;
    first_long_n = first_long_q;
    byte_data_n  = byte_data_q;
    byte_valid_n = 1'b0;
    block_done_n = 1'b0;
    chk_ok_n     = chk_ok_q;
    err_n        = 1'b0;
    err_code_n   = err_code_q;

    if (!enable) begin
      state_n = ST_SEEK;
      pilot_n = '0;
      bytes_n = '0;
      bits_n  = '0;
      half_n  = 1'b0;
      xor_n   = '0;
    end else if (hw_valid) begin
      unique case (state_q)
        ST_SEEK: begin
          if (hw_cls == HW_LONG) begin
            if (pilot_q == LOCK_LAST) begin
              state_n = ST_ARMED;
              pilot_n = '0;
              len_n   = (blk_len == '0) ? 16'd1 : blk_len;
              bytes_n = '0;
              xor_n   = '0;
            end else begin
              pilot_n = pilot_q + 8'd1;
            end
          end else begin
            pilot_n = '0;
          end
        end
        ST_ARMED: begin
          unique case (hw_cls)
            HW_LONG: ;
            HW_SHORT: begin
              // This short half-wave is already the first half of bit 7 of byte 0.
              state_n      = ST_DATA;
              half_n       = 1'b1;
              first_long_n = 1'b0;
              bits_n       = '0;
              shift_n      = '0;
            end
            default: state_n = ST_SEEK;
          endcase
        end
        ST_DATA: begin
          if (hw_cls == HW_GLITCH) begin
            state_n    = ST_SEEK;
            err_n      = 1'b1;
            err_code_n = ERR_GLITCH;
          end else if (hw_cls == HW_TIMEOUT) begin
            state_n    = ST_SEEK;
            err_n      = 1'b1;
            err_code_n = ERR_TIMEOUT;
          end else if (!half_q) begin
            half_n       = 1'b1;
            first_long_n = new_bit;
          end else begin
            half_n = 1'b0;
            if (new_bit != first_long_q) begin
              state_n    = ST_SEEK;
              err_n      = 1'b1;
              err_code_n = ERR_PAIR;
            end else begin
              shift_n = shifted;
              bits_n  = bits_q + 3'd1;
              if (bits_q == 3'd7) begin
                byte_valid_n = 1'b1;
                byte_data_n  = shifted;
                xor_n        = xor_next;
                bytes_n      = bytes_inc;
                if (bytes_inc == len_q) begin
                  block_done_n = 1'b1;
                  chk_ok_n     = (xor_next == '0);
                  state_n      = ST_SEEK;
                end
              end
            end
          end
        end
        default: state_n = ST_SEEK;
      endcase
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign block_done = block_done_q;
  assign chk_ok     = chk_ok_q;
  assign locked     = (state_q != ST_SEEK);
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_tape_ear_decoder.sv
// Directed bench for tape_ear_decoder at a scaled clock: BIT0_HALF=20, BIT1_HALF=40,
// MIN=10, SPLIT=30, MAX=60 clocks.
module tb_tape_ear_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ear_in;
  logic [15:0] blk_len;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        block_done;
  logic        chk_ok;
  logic        locked;
  logic        err;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  logic [7:0] q_bytes[$];
  logic       q_done[$];
  logic       q_chk[$];
  int         done_cnt   = 0;
  int         err_cnt    = 0;
  int         locked_cnt = 0;
  logic [1:0] last_code  = '0;

  int b0, d0, c0, e0, l0;

  logic [7:0] blk1[17] = '{8'h00, 8'h07, 8'h00, 8'h00, 8'h5B, 8'h48, 8'h45, 8'h4C, 8'h4C,
                           8'h4F, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
  logic [7:0] blk2[10] = '{8'h0A, 8'h00, 8'hF0, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h00};

  tape_ear_decoder #(
    .CLK_FREQ   (96000),
    .BIT0_FREQ  (2400),
    .BIT1_FREQ  (1200),
    .PILOT_LOCK (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ear_in     (ear_in),
    .blk_len    (blk_len),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .block_done (block_done),
    .chk_ok     (chk_ok),
    .locked     (locked),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // Record strobed outputs once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (byte_valid) begin
      q_bytes.push_back(byte_data);
      q_done.push_back(block_done);
    end
    if (block_done) begin
      done_cnt = done_cnt + 1;
      q_chk.push_back(chk_ok);
    end
    if (err) begin
      err_cnt   = err_cnt + 1;
      last_code = err_code;
    end
    if (locked) locked_cnt = locked_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hw(input int n);
    ear_in = ~ear_in;
    repeat (n) @(negedge clk);
  endtask

  task automatic pilot(input int n);
    for (int i = 0; i < n; i++) hw(40);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      hw(v[i] ? 40 : 20);
      hw(v[i] ? 40 : 20);
    end
  endtask

  // Closing edge for the last half-wave, then silence long enough to settle.
  task automatic finish_tx();
    ear_in = ~ear_in;
    repeat (80) @(negedge clk);
  endtask

  task automatic snap();
    b0 = q_bytes.size();
    d0 = done_cnt;
    c0 = q_chk.size();
    e0 = err_cnt;
    l0 = locked_cnt;
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    ear_in  = 1'b0;
    blk_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_byte_data", byte_data, 8'h00);
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_block_done", block_done, 1'b0);
    chk("rst_chk_ok", chk_ok, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_code", err_code, 2'd0);
    reset  = 1'b0;
    enable = 1'b1;
    repeat (100) @(negedge clk);

    // 1: two identical bytes, XOR cancels.
    snap();
    blk_len = 16'd2;
    pilot(8);
    send_byte(8'h3C);
    send_byte(8'h3C);
    finish_tx();
    chk("t1_nbytes", q_bytes.size() - b0, 2);
    chk("t1_byte0", q_bytes[b0], 8'h3C);
    chk("t1_byte1", q_bytes[b0+1], 8'h3C);
    chk("t1_done_on_byte0", q_done[b0], 1'b0);
    chk("t1_done_on_byte1", q_done[b0+1], 1'b1);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_chk_ok", q_chk[c0], 1'b1);
    chk("t1_err_cnt", err_cnt - e0, 0);

    // 2: single byte block, nonzero XOR.
    snap();
    blk_len = 16'd1;
    pilot(8);
    send_byte(8'h5A);
    finish_tx();
    chk("t2_nbytes", q_bytes.size() - b0, 1);
    chk("t2_byte0", q_bytes[b0], 8'h5A);
    chk("t2_done_on_byte0", q_done[b0], 1'b1);
    chk("t2_chk_ok", q_chk[c0], 1'b0);
    chk("t2_chk_ok_held", chk_ok, 1'b0);

    // 2b: blk_len 0 behaves as 1.
    snap();
    blk_len = 16'd0;
    pilot(8);
    send_byte(8'h21);
    finish_tx();
    chk("t2b_nbytes", q_bytes.size() - b0, 1);
    chk("t2b_done_cnt", done_cnt - d0, 1);
    chk("t2b_locked", locked, 1'b0);

    // 3: two back-to-back blocks, inter-block pilot re-arms.
    // XOR of block 1 is 0x3E, of block 2 is 0xB5: neither checks ok.
    snap();
    blk_len = 16'd17;
    pilot(8);
    for (int i = 0; i < 17; i++) send_byte(blk1[i]);
    blk_len = 16'd10;
    pilot(8);
    for (int i = 0; i < 10; i++) send_byte(blk2[i]);
    finish_tx();
    chk("t3_nbytes", q_bytes.size() - b0, 27);
    for (int i = 0; i < 17; i++) chk($sformatf("t3_blk1_byte%0d", i), q_bytes[b0+i], blk1[i]);
    for (int i = 0; i < 10; i++) chk($sformatf("t3_blk2_byte%0d", i), q_bytes[b0+17+i], blk2[i]);
    chk("t3_done_cnt", done_cnt - d0, 2);
    chk("t3_done_on_16", q_done[b0+16], 1'b1);
    chk("t3_done_on_15", q_done[b0+15], 1'b0);
    chk("t3_done_on_26", q_done[b0+26], 1'b1);
    chk("t3_chk_blk1", q_chk[c0], 1'b0);
    chk("t3_chk_blk2", q_chk[c0+1], 1'b0);
    chk("t3_err_cnt", err_cnt - e0, 0);

    // 4a: glitch half-wave inside DATA.
    snap();
    blk_len = 16'd4;
    pilot(8);
    hw(20); hw(20); hw(20); hw(4);
    ear_in = ~ear_in;
    repeat (10) @(negedge clk);
    chk("t4a_err_cnt", err_cnt - e0, 1);
    chk("t4a_err_code", last_code, 2'd1);
    chk("t4a_err_code_held", err_code, 2'd1);
    chk("t4a_locked", locked, 1'b0);
    chk("t4a_nbytes", q_bytes.size() - b0, 0);
    repeat (80) @(negedge clk);

    // 4b: short followed by long in one pair.
    snap();
    pilot(8);
    hw(20); hw(40);
    ear_in = ~ear_in;
    repeat (10) @(negedge clk);
    chk("t4b_err_cnt", err_cnt - e0, 1);
    chk("t4b_err_code", last_code, 2'd2);
    chk("t4b_locked", locked, 1'b0);
    repeat (80) @(negedge clk);

    // 5: silence mid-byte; timeout strobe lands about 64 clocks after the last edge.
    snap();
    pilot(8);
    hw(20); hw(20); hw(40); hw(40);
    ear_in = ~ear_in;
    repeat (50) @(negedge clk);
    chk("t5_no_err_yet", err_cnt - e0, 0);
    chk("t5_still_locked", locked, 1'b1);
    repeat (40) @(negedge clk);
    chk("t5_err_cnt", err_cnt - e0, 1);
    chk("t5_err_code", last_code, 2'd3);
    chk("t5_nbytes", q_bytes.size() - b0, 0);
    chk("t5_done_cnt", done_cnt - d0, 0);
    chk("t5_locked", locked, 1'b0);

    // 6a: three long half-waves are not enough pilot.
    snap();
    hw(40); hw(40); hw(40);
    for (int i = 0; i < 6; i++) hw(20);
    finish_tx();
    chk("t6a_never_locked", locked_cnt - l0, 0);
    chk("t6a_err_cnt", err_cnt - e0, 0);

    // Good block so byte_data/chk_ok hold nonzero values for the next checks.
    snap();
    blk_len = 16'd2;
    pilot(8);
    send_byte(8'h3C);
    send_byte(8'h3C);
    finish_tx();
    chk("t7_setup_chk", q_chk[c0], 1'b1);

    // 7: enable low mid-block drops lock, holds data outputs.
    pilot(8);
    hw(20); hw(20);
    chk("t7_locked_before", locked, 1'b1);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("t7_locked", locked, 1'b0);
    chk("t7_byte_data_held", byte_data, 8'h3C);
    chk("t7_chk_ok_held", chk_ok, 1'b1);
    chk("t7_err_code_held", err_code, 2'd3);
    enable = 1'b1;
    repeat (80) @(negedge clk);

    // 6b: reset mid-byte clears every output on the next cycle.
    pilot(8);
    hw(20); hw(20); hw(40); hw(40); hw(20);
    chk("t6b_locked_before", locked, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6b_byte_data", byte_data, 8'h00);
    chk("t6b_byte_valid", byte_valid, 1'b0);
    chk("t6b_block_done", block_done, 1'b0);
    chk("t6b_chk_ok", chk_ok, 1'b0);
    chk("t6b_locked", locked, 1'b0);
    chk("t6b_err", err, 1'b0);
    chk("t6b_err_code", err_code, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
